// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM.
// States, opcodes and datapath select codes.
package riscv_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_LUI      = 4'd8;
  localparam state_t S_ALUWB    = 4'd9;
  localparam state_t S_BRANCH   = 4'd10;
  localparam state_t S_JAL      = 4'd11;
  localparam state_t S_JALR     = 4'd12;
  localparam state_t S_JALLINK  = 4'd13;
  localparam state_t S_TRAP     = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_control_instr_decode.sv
// Opcode/funct3 decode: DECODE successor state, immediate format
// and illegal-branch flag.
import riscv_ctrl_pkg::*;

module instr_decode (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output state_t     decode_next,
  output logic [2:0] imm_src,
  output logic       branch_illegal
);

  always_comb begin
    decode_next = S_TRAP;
    unique case (1'b1)
      (opcode == OP_LOAD),
      (opcode == OP_STORE):  decode_next = S_MEMADR;
      (opcode == OP_R):      decode_next = S_EXECUTER;
      (opcode == OP_IMM):    decode_next = S_EXECUTEI;
      (opcode == OP_BRANCH): decode_next = S_BRANCH;
      (opcode == OP_JAL):    decode_next = S_JAL;
      (opcode == OP_JALR):   decode_next = S_JALR;
      (opcode == OP_LUI):    decode_next = S_LUI;
      (opcode == OP_AUIPC):  decode_next = S_ALUWB;
      default:               decode_next = S_TRAP;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    unique case (1'b1)
      (opcode == OP_STORE):  imm_src = IMM_S;
      (opcode == OP_BRANCH): imm_src = IMM_B;
      (opcode == OP_JAL):    imm_src = IMM_J;
      (opcode == OP_LUI),
      (opcode == OP_AUIPC):  imm_src = IMM_U;
      default:               imm_src = IMM_I;
    endcase
  end

  assign branch_illegal = (funct3[2:1] == 2'b01);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM driving ALU command, datapath
// selects and enables, with MemReady wait states.
import riscv_ctrl_pkg::*;

module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [1:0]  ALUOp,
  output logic [2:0]  ALUFunct3,
  output logic [6:0]  ALUFunct7,
  output logic        IllegalInstr
);

  state_t     state;
  state_t     next_state;
  state_t     decode_next;
  logic [2:0] imm_src;
  logic       branch_illegal;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_bits;

  assign opcode = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign funct7 = Instr[31:25];
  assign unused_bits = ^{Instr[24:15], Instr[11:7]};

  instr_decode u_dec (
    .opcode         (opcode),
    .funct3         (funct3),
    .decode_next    (decode_next),
    .imm_src        (imm_src),
    .branch_illegal (branch_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ImmSrc       = IMM_I;
    ALUOp        = ALUOP_ADD;
    ALUFunct3    = 3'b000;
    ALUFunct7    = 7'b0000000;
    IllegalInstr = 1'b0;
    if (!reset) begin
      ImmSrc = imm_src;
      unique case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURES;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcA    = SRCA_OLDPC;
          ALUSrcB    = SRCB_IMM;
          next_state = decode_next;
        end
        S_MEMADR: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_IMM;
          next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
          if (MemReady) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc  = RES_DATA;
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          if (MemReady) next_state = S_FETCH;
        end
        S_EXECUTER: begin
          ALUSrcA    = SRCA_RS1;
          ALUOp      = ALUOP_R;
          ALUFunct3  = funct3;
          ALUFunct7  = funct7;
          next_state = S_ALUWB;
        end
        S_EXECUTEI: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_IMM;
          ALUOp      = ALUOP_I;
          ALUFunct3  = funct3;
          // only shifts carry a real funct7; elsewhere it is immediate
          ALUFunct7  = (funct3 == 3'b101) ? funct7 : 7'b0000000;
          next_state = S_ALUWB;
        end
        S_LUI: begin
          ALUSrcA    = SRCA_ZERO;
          ALUSrcB    = SRCB_IMM;
          next_state = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = SRCA_RS1;
          next_state = S_FETCH;
          unique case (funct3[2:1])
            2'b00: begin
              ALUOp   = ALUOP_SUB;
              PCWrite = Zero ^ funct3[0];
            end
            2'b01: next_state = S_TRAP;
            default: begin
              // signed/unsigned less-than via SLT/SLTU
              ALUOp     = ALUOP_R;
              ALUFunct3 = {2'b01, funct3[1]};
              PCWrite   = ~Zero ^ funct3[0];
            end
          endcase
          if (branch_illegal) PCWrite = 1'b0;
        end
        S_JAL: begin
          ALUSrcA    = SRCA_OLDPC;
          ALUSrcB    = SRCB_FOUR;
          PCWrite    = 1'b1;
          next_state = S_ALUWB;
        end
        S_JALR: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_IMM;
          ResultSrc  = RES_ALURES;
          PCWrite    = 1'b1;
          next_state = S_JALLINK;
        end
        S_JALLINK: begin
          ALUSrcA    = SRCA_OLDPC;
          ALUSrcB    = SRCB_FOUR;
          next_state = S_ALUWB;
        end
        S_TRAP: begin
          IllegalInstr = 1'b1;
          next_state   = S_TRAP;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control.
// One row per clock: inputs and full expected output word.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc, ALUFunct3;
  logic [6:0]  ALUFunct7;
  logic        IllegalInstr;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .Instr        (Instr),
    .Zero         (Zero),
    .MemReady     (MemReady),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .ALUOp        (ALUOp),
    .ALUFunct3    (ALUFunct3),
    .ALUFunct7    (ALUFunct7),
    .IllegalInstr (IllegalInstr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    logic [27:0] exp;
  } vec_t;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SRAI  = 32'h40335293;
  localparam logic [31:0] I_ADDI  = 32'hC0000093;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_LW    = 32'h0000A283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  // enables: {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite}
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_FRDY = 6'b101010;
  localparam logic [5:0] E_FWT  = 6'b001000;
  localparam logic [5:0] E_RW   = 6'b000001;
  localparam logic [5:0] E_PCW  = 6'b100000;
  localparam logic [5:0] E_MRD  = 6'b011000;
  localparam logic [5:0] E_MWR  = 6'b010100;

  logic [27:0] act;
  assign act = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp,
                ALUFunct3, ALUFunct7, IllegalInstr};

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst, input logic [31:0] instr,
    input logic zero, input logic rdy, input logic [5:0] en,
    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
    input logic [2:0] imm, input logic [1:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic ill);
    vec_t r;
    r.rst   = rst;
    r.instr = instr;
    r.zero  = zero;
    r.rdy   = rdy;
    r.exp   = {en, rs, sa, sb, imm, op, f3, f7, ill};
    return r;
  endfunction

  task automatic run(input vec_t r, input string nm);
    reset    = r.rst;
    Instr    = r.instr;
    Zero     = r.zero;
    MemReady = r.rdy;
    @(negedge clk);
    n_chk++;
    if (act !== r.exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %h expected %h", nm, act, r.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ADD: FETCH, DECODE, EXECUTER, ALUWB
    tbl.push_back(v(1, I_ADD, 0, 1, E_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_ADD, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_ADD, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_ADD, 0, 1, E_NONE, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_ADD, 0, 1, E_RW,   2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    // SRAI keeps funct7
    tbl.push_back(v(0, I_SRAI, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_SRAI, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_SRAI, 0, 1, E_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 2'b11, 3'b101, 7'h20, 0));
    tbl.push_back(v(0, I_SRAI, 0, 1, E_RW,   2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    // ADDI with negative immediate: funct7 masked
    tbl.push_back(v(0, I_ADDI, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_ADDI, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_ADDI, 0, 1, E_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 2'b11, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_ADDI, 0, 1, E_RW,   2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0));
    // BLT taken (Zero=0)
    tbl.push_back(v(0, I_BLT, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_BLT, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_BLT, 0, 1, E_PCW,  2'b00, 2'b10, 2'b00, 3'b010, 2'b10, 3'b010, 7'h00, 0));
    // BLT not taken (Zero=1)
    tbl.push_back(v(0, I_BLT, 1, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_BLT, 1, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_BLT, 1, 1, E_NONE, 2'b00, 2'b10, 2'b00, 3'b010, 2'b10, 3'b010, 7'h00, 0));
    // BNE taken (Zero=0)
    tbl.push_back(v(0, I_BNE, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_BNE, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_BNE, 0, 1, E_PCW,  2'b00, 2'b10, 2'b00, 3'b010, 2'b01, 3'b000, 7'h00, 0));
    // AUIPC: three cycles
    tbl.push_back(v(0, I_AUIPC, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b100, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_AUIPC, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b100, 2'b00, 3'b000, 7'h00, 0));
    tbl.push_back(v(0, I_AUIPC, 0, 1, E_RW,   2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 3'b000, 7'h00, 0));

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i], $sformatf("row%0d", i));

    // LW with a fetch wait state and three read wait states
    run(v(0, I_LW, 0, 0, E_FWT,  2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0), "lw_fetch_wait");
    run(v(0, I_LW, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000, 7'h00, 0), "lw_fetch");
    run(v(0, I_LW, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000, 7'h00, 0), "lw_decode");
    run(v(0, I_LW, 0, 1, E_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 7'h00, 0), "lw_memadr");
    for (int i = 0; i < 3; i++)
      run(v(0, I_LW, 0, 0, E_MRD, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0), "lw_memread_wait");
    run(v(0, I_LW, 0, 1, E_MRD,  2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0), "lw_memread_done");
    run(v(0, I_LW, 0, 1, E_RW,   2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0), "lw_memwb");

    // SW interrupted by reset in its second MEMWRITE cycle
    run(v(0, I_SW, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b001, 2'b00, 3'b000, 7'h00, 0), "sw_fetch");
    run(v(0, I_SW, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b001, 2'b00, 3'b000, 7'h00, 0), "sw_decode");
    run(v(0, I_SW, 0, 1, E_NONE, 2'b00, 2'b10, 2'b01, 3'b001, 2'b00, 3'b000, 7'h00, 0), "sw_memadr");
    run(v(0, I_SW, 0, 0, E_MWR,  2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 3'b000, 7'h00, 0), "sw_memwrite");
    run(v(1, I_SW, 0, 0, E_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0), "sw_reset");
    run(v(0, I_SW, 0, 0, E_FWT,  2'b00, 2'b00, 2'b00, 3'b001, 2'b00, 3'b000, 7'h00, 0), "sw_after_reset");

    // illegal opcode traps until reset
    run(v(0, I_BAD, 0, 1, E_FRDY, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000, 7'h00, 0), "bad_fetch");
    run(v(0, I_BAD, 0, 1, E_NONE, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000, 7'h00, 0), "bad_decode");
    for (int i = 0; i < 100; i++)
      run(v(0, I_BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            E_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 1), "trap_hold");
    run(v(1, I_BAD, 0, 1, E_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0), "trap_reset");
    run(v(0, I_BAD, 0, 0, E_FWT,  2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 7'h00, 0), "trap_refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle RV32I control FSM that drives the ALU's command interface: ALUOp, ALUFunct3 and ALUFunct7. It also drives the datapath mux selects and write enables, and it consumes the ALU Zero flag to resolve branches. It sits between the instruction register and the existing combinational ALU and sequences each instruction through FETCH, DECODE, execute and writeback. Memory accesses use a MemReady handshake so wait-state memories stall the FSM.

Parameters:
none (encodings are fixed in the shared package)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Instr  in  32  instruction register contents; stable from DECODE onward
Zero  in  1  ALU Zero flag
MemReady  in  1  memory completes the current MemRead/MemWrite this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register and OldPC enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
ImmSrc  out  3  immediate format: I = 000, S = 001, B = 010, J = 011, U = 100
ALUOp  out  2  ALU operation class
ALUFunct3  out  3  funct3 presented to the ALU
ALUFunct7  out  7  funct7 presented to the ALU
IllegalInstr  out  1  high while the FSM is in TRAP

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset:
  - While reset is high, all enables (PCWrite, MemRead, MemWrite, IRWrite, RegWrite) and IllegalInstr are 0.
  - While reset is high, selects, ALUOp, ALUFunct3 and ALUFunct7 are 0.
  - State is FETCH after the reset edge. This applies to reset mid-instruction, including a pending MemWrite.
- Outputs are decoded combinationally from state, Instr, Zero and MemReady. Any output not listed for a state is 0.
- ImmSrc is decoded from Instr[6:0] in every state; an unknown opcode gives 000.
- FETCH: AdrSrc = 0, MemRead = 1.
  - MemReady = 0: hold FETCH with no other enables.
  - MemReady = 1, same cycle: IRWrite = 1, PCWrite = 1, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10; next state DECODE.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00, so ALUOut = OldPC + imm (branch/JAL target). Next state by opcode:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> ALUWB (AUIPC result is already in ALUOut)
  - anything else -> TRAP
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc = 1, ResultSrc = 00, MemRead = 1. Hold until MemReady = 1, then go to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1. Next state FETCH.
- MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1. Hold until MemReady = 1, then go to FETCH.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10, ALUFunct3 = Instr[14:12], ALUFunct7 = Instr[31:25]. Next state ALUWB.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 11, ALUFunct3 = Instr[14:12].
  - ALUFunct7 = Instr[31:25] only when funct3 = 101; otherwise 0, so immediate bit 30 never selects SUB or SRA.
  - Next state ALUWB.
- LUI: ALUSrcA = 11, ALUSrcB = 01, ALUOp = 00. Next state ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1. Next state FETCH.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, ResultSrc = 00, PCWrite = taken; next state FETCH. Taken depends on funct3:
  - funct3 = 00x (BEQ/BNE): ALUOp = 01; taken = Zero ^ funct3[0].
  - funct3 = 10x (BLT/BGE): ALUOp = 10, ALUFunct3 = 010, ALUFunct7 = 0; taken = ~Zero ^ funct3[0].
  - funct3 = 11x (BLTU/BGEU): same as 10x but ALUFunct3 = 011.
  - funct3 = 01x: TRAP with no PCWrite.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1. Next state ALUWB (writes OldPC + 4).
- JALR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00, ResultSrc = 10, PCWrite = 1. Next state JALLINK. The datapath clears PC bit 0.
- JALLINK: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00. Next state ALUWB.
- TRAP: IllegalInstr = 1 with no enables; the FSM stays in TRAP until reset.
- Latency in cycles with zero wait states:
  - 3: AUIPC, branch
  - 4: R-type, I-type, LUI, JAL, store
  - 5: load, JALR
  - Each cycle with MemReady low adds one cycle.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUOp codes (ADD = 00, SUB = 01, R = 10, I = 11)
  - ALUSrcA, ALUSrcB, ResultSrc and ImmSrc encodings
- One sub-module, instr_decode: combinational mapping from opcode/funct3 to DECODE's next state, ImmSrc and a branch-illegal flag.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), MemReady = 1 -> states FETCH, DECODE, EXECUTER, ALUWB. In EXECUTER: ALUOp = 10, ALUFunct3 = 000, ALUFunct7 = 0000000. RegWrite = 1 only in cycle 4.
- Immediate ALU ops:
  - SRAI (0x40335293) -> ALUOp = 11, ALUFunct3 = 101, ALUFunct7 = 0100000.
  - ADDI x1,x0,-1024 (0xC0000093) -> ALUFunct7 = 0000000.
- Branches:
  - BLT (funct3 = 100) with Zero = 0 -> PCWrite = 1, ALUOp = 10, ALUFunct3 = 010.
  - Same BLT with Zero = 1 -> PCWrite = 0.
  - BNE with Zero = 0 -> PCWrite = 1, ALUOp = 01.
- LW with MemReady low for 3 cycles in MEMREAD -> MemRead held 4 cycles, AdrSrc = 1. Then MEMWB for one cycle with RegWrite = 1 and ResultSrc = 01.
- SW with reset asserted during the second MEMWRITE cycle -> MemWrite = 0 during reset; state is FETCH after the edge and MemRead = 1 once reset drops.
- Instr = 0x0000007F -> TRAP after DECODE. IllegalInstr = 1 and all enables stay 0 for 100 cycles; reset returns the FSM to FETCH.
